// File: rtl/lcd_init_pkg.sv
// Shared constants for the LCD power-on initialisation sequencer:
// phase lengths, enable-strobe timing, state codes and the command table.
package lcd_init_pkg;

  localparam int unsigned CNT_W = 20;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PWR_CYC    = 20'd750000;
  localparam cnt_t INIT1_CYC  = 20'd205000;
  localparam cnt_t INIT2_CYC  = 20'd5000;
  localparam cnt_t NIB_CYC    = 20'd2000;
  localparam cnt_t CMD_HI_CYC = 20'd50;
  localparam cnt_t CLR_LO_CYC = 20'd82000;

  localparam cnt_t E_SETUP = 20'd2;
  localparam cnt_t E_WIDTH = 20'd12;

  typedef logic [2:0] state_t;
  localparam state_t ST_WAIT_PWR = 3'd0;
  localparam state_t ST_INIT_NIB = 3'd1;
  localparam state_t ST_CMD_HI   = 3'd2;
  localparam state_t ST_CMD_LO   = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

  // Function Set, Entry Mode, Display On, Clear -- sent in this order.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h06;
      2'd2:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_init_strobe.sv
// Enable-strobe timing inside one nibble-write phase, derived from the
// phase counter: setup cycles with E low, then a fixed-width E pulse.
module lcd_init_strobe
  import lcd_init_pkg::*;
(
  input  logic [CNT_W-1:0] cnt,
  input  logic             active,
  output logic             e
);

  always_comb begin
    e = active && (cnt >= E_SETUP) && (cnt < (E_SETUP + E_WIDTH));
  end

endmodule

// File: rtl/lcd_init.sv
// LCD 4-bit interface power-on initialisation sequencer: power-on wait,
// four reset nibbles, four configuration commands, then a sticky done.
module lcd_init
  import lcd_init_pkg::*;
#(
  parameter cnt_t PWR_LEN    = PWR_CYC,
  parameter cnt_t INIT1_LEN  = INIT1_CYC,
  parameter cnt_t INIT2_LEN  = INIT2_CYC,
  parameter cnt_t NIB_LEN    = NIB_CYC,
  parameter cnt_t CMD_HI_LEN = CMD_HI_CYC,
  parameter cnt_t CLR_LO_LEN = CLR_LO_CYC
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [3:0] init_D,
  output logic       init_E,
  output logic       init_RS,
  output logic       init_RW,
  output logic       init_done
);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  cnt_t       cnt_q, cnt_d;

  cnt_t       phase_len;
  logic       last_cyc;
  logic [7:0] cmd_w;
  logic       nib_active;
  logic       strobe_e;

  always_comb begin
    cmd_w = cmd_byte(idx_q);
    case (state_q)
      ST_WAIT_PWR: phase_len = PWR_LEN;
      ST_INIT_NIB: phase_len = (idx_q == 2'd0) ? INIT1_LEN :
                               (idx_q == 2'd1) ? INIT2_LEN : NIB_LEN;
      ST_CMD_HI:   phase_len = CMD_HI_LEN;
      ST_CMD_LO:   phase_len = (idx_q == 2'd3) ? CLR_LO_LEN : NIB_LEN;
      default:     phase_len = '0;
    endcase
    last_cyc = (state_q != ST_DONE) && (cnt_q == (phase_len - 20'd1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = (state_q == ST_DONE) ? cnt_q : cnt_q + 20'd1;
    if (last_cyc) begin
      cnt_d = '0;
      case (state_q)
        ST_WAIT_PWR: begin
          state_d = ST_INIT_NIB;
          idx_d   = '0;
        end
        ST_INIT_NIB: begin
          if (idx_q == 2'd3) begin
            state_d = ST_CMD_HI;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        ST_CMD_HI: state_d = ST_CMD_LO;
        ST_CMD_LO: begin
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CMD_HI;
            idx_d   = idx_q + 2'd1;
          end
        end
        default: state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_WAIT_PWR;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nib_active = (state_q == ST_INIT_NIB) || (state_q == ST_CMD_HI) ||
                      (state_q == ST_CMD_LO);

  lcd_init_strobe u_strobe (
    .cnt    (cnt_q),
    .active (nib_active),
    .e      (strobe_e)
  );

  // Outputs decode registered state only, so reset clears them without a clock.
  always_comb begin
    case (state_q)
      ST_INIT_NIB: init_D = (idx_q == 2'd3) ? 4'h2 : 4'h3;
      ST_CMD_HI:   init_D = cmd_w[7:4];
      ST_CMD_LO:   init_D = cmd_w[3:0];
      default:     init_D = '0;
    endcase
    init_E    = strobe_e;
    init_RS   = 1'b0;
    init_RW   = 1'b0;
    init_done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_lcd_init.sv
// Self-checking bench for lcd_init with shortened phase lengths, checked
// cycle by cycle against a phase-table model of the init sequence.
module tb_lcd_init;

  localparam int unsigned T_PWR   = 3000;
  localparam int unsigned T_INIT1 = 900;
  localparam int unsigned T_INIT2 = 300;
  localparam int unsigned T_NIB   = 120;
  localparam int unsigned T_HI    = 50;
  localparam int unsigned T_CLR   = 700;
  localparam int unsigned NPH     = 13;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] init_D;
  logic       init_E, init_RS, init_RW, init_done;

  int unsigned tests = 0;
  int unsigned fails = 0;

  int unsigned ph_len [NPH];
  logic [3:0]  ph_nib [NPH];
  logic [3:0]  exp_d  [12];
  int unsigned total;

  int unsigned p_start[$];
  int unsigned p_fall[$];
  logic [3:0]  p_d[$];
  int unsigned done_n;

  always #5 CLK = ~CLK;

  lcd_init #(
    .PWR_LEN    (20'(T_PWR)),
    .INIT1_LEN  (20'(T_INIT1)),
    .INIT2_LEN  (20'(T_INIT2)),
    .NIB_LEN    (20'(T_NIB)),
    .CMD_HI_LEN (20'(T_HI)),
    .CLR_LO_LEN (20'(T_CLR))
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .init_D    (init_D),
    .init_E    (init_E),
    .init_RS   (init_RS),
    .init_RW   (init_RW),
    .init_done (init_done)
  );

  // {D, E, done} expected n clock edges after reset release.
  function automatic logic [5:0] model_out(input int unsigned n);
    int unsigned off;
    off = n;
    for (int p = 0; p < NPH; p++) begin
      if (off < ph_len[p])
        return {ph_nib[p], (p != 0) && (off >= 2) && (off < 14), 1'b0};
      off -= ph_len[p];
    end
    return 6'b0000_0_1;
  endfunction

  task automatic check(input string tag, input int unsigned n,
                       input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, n, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 0, {24'b0, init_D, init_E, init_RS, init_RW, init_done}, 32'h0);
  endtask

  // Runs cycles 0..ncyc after a release performed at the current negedge.
  task automatic run_seq(input int unsigned ncyc, input bit full);
    logic [5:0] m;
    logic       prev_e;
    bit         done_seen;
    prev_e    = 1'b0;
    done_seen = 1'b0;
    done_n    = 0;
    p_start.delete();
    p_fall.delete();
    p_d.delete();
    for (int unsigned n = 0; n <= ncyc; n++) begin
      if (n != 0) @(negedge CLK);
      m = model_out(n);
      check("seq", n, {24'b0, init_D, init_E, init_RS, init_RW, init_done},
            {24'b0, m[5:1], 2'b00, m[0]});
      if (init_E && !prev_e) begin
        p_start.push_back(n);
        p_d.push_back(init_D);
      end
      if (!init_E && prev_e) p_fall.push_back(n);
      if (init_done && !done_seen) begin
        done_seen = 1'b1;
        done_n    = n;
      end
      prev_e = init_E;
    end
    check("first_e", 0, (p_start.size() > 0) ? p_start[0] : 0, T_PWR + 2);
    if (full) begin
      check("pulse_count", 0, p_start.size(), 12);
      check("fall_count", 0, p_fall.size(), 12);
      check("done_cycle", 0, done_n, total);
      if (p_start.size() == 12 && p_fall.size() == 12) begin
        for (int k = 0; k < 12; k++) begin
          check("pulse_d", k, {28'b0, p_d[k]}, {28'b0, exp_d[k]});
          check("pulse_w", k, p_fall[k] - p_start[k], 12);
        end
        for (int k = 5; k < 11; k += 2)
          check("lo_gap", k, (p_start[k+1] - 2) - p_fall[k], T_NIB - 14);
        check("clr_gap", 11, done_n - p_fall[11], T_CLR - 14);
      end
    end
  endtask

  initial begin
    int unsigned s5;
    ph_len = '{T_PWR, T_INIT1, T_INIT2, T_NIB, T_NIB,
               T_HI, T_NIB, T_HI, T_NIB, T_HI, T_NIB, T_HI, T_CLR};
    ph_nib = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h2,
               4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    exp_d  = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
               4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    total = 0;
    for (int p = 0; p < NPH; p++) total += ph_len[p];

    // Held in reset from time zero.
    repeat (3) @(negedge CLK);
    check_idle("reset_state");

    // Full sequence plus a stretch of idle time after done.
    RST_N = 1'b1;
    run_seq(total + $urandom_range(100, 300), 1'b1);

    // Reset after done clears done without a clock edge, then restarts.
    #2 RST_N = 1'b0;
    #1 check_idle("rst_after_done");
    repeat ($urandom_range(1, 5)) @(negedge CLK);
    check_idle("rst_hold");
    RST_N = 1'b1;
    run_seq(T_PWR + $urandom_range(20, 200), 1'b0);

    // Fresh start, then abort in the middle of the fifth E pulse.
    #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    s5 = T_PWR + T_INIT1 + T_INIT2 + 2 * T_NIB + 2 + $urandom_range(0, 11);
    run_seq(s5, 1'b0);
    check("pre_rst_e", s5, {31'b0, init_E}, 32'h1);
    #2 RST_N = 1'b0;
    #1 check_idle("async_rst_mid_e");
    repeat ($urandom_range(1, 5)) @(negedge CLK);
    check_idle("rst_hold2");
    RST_N = 1'b1;
    run_seq(total + $urandom_range(20, 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
